xor_chain_decoder: RTL and testbench

- Receive-side decoder for the 8-bit XOR-chained offset code produced by the student_circuit encoder path: y[n] = x[n] ^ ((x[n-1] + OFFSET) mod 256), with x[-1] = SEED.
- Recovers x[n] from the encoded stream under a valid/ready handshake, frames bytes into fixed-length frames and re-seeds the chain at every frame boundary.
- Optionally checks a trailing XOR check byte per frame.
- Sits between the link/capture logic and the downstream byte consumer.

---
 rtl/xor_chain_decoder.sv | 125 ++++++++++++
 tb/tb_xor_chain_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/xor_chain_decoder.sv
// Receive-side decoder for the XOR-chained offset code: x = y ^ (prev + OFFSET), re-seeded per frame.
// Define XOR_CHAIN_DEC_CHECK_EN to expect and verify a trailing XOR check byte after every frame.
module xor_chain_decoder #(
    parameter logic [7:0] OFFSET    = 8'h22,
    parameter logic [7:0] SEED      = 8'h03,
    parameter int         FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       sync_clear,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [7:0] byte_count,
    output logic       check_err
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    logic       r_run;
    logic [7:0] r_prev;
    logic [7:0] r_count;
    logic       r_out_valid;
    logic [7:0] r_out_data;
    logic       r_out_last;

    logic       w_accept;
    logic       w_data_beat;
    logic       w_is_last;
    logic [7:0] w_chain;
    logic [7:0] w_decoded;

    // r_run holds in_ready low until the first edge after reset release
    assign in_ready  = r_run && !sync_clear && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_chain   = r_prev + OFFSET;
    assign w_decoded = in_data ^ w_chain;
    assign w_is_last = (r_count == LAST_IDX);

`ifdef XOR_CHAIN_DEC_CHECK_EN
    typedef enum logic {S_DATA, S_CHECK} state_t;

    state_t     r_state;
    logic [7:0] r_frame_xor;
    logic       r_check_err;

    assign w_data_beat = w_accept && (r_state == S_DATA);
    assign check_err   = r_check_err;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= S_DATA;
            r_frame_xor <= 8'h00;
            r_check_err <= 1'b0;
        end else if (sync_clear) begin
            r_state     <= S_DATA;
            r_frame_xor <= 8'h00;
            r_check_err <= 1'b0;
        end else if (w_accept) begin
            if (r_state == S_DATA) begin
                r_frame_xor <= r_frame_xor ^ w_decoded;
                if (w_is_last) begin
                    r_state <= S_CHECK;
                end
            end else begin
                // Raw check byte: compared, never forwarded, and the next frame starts clean
                if (in_data != r_frame_xor) begin
                    r_check_err <= 1'b1;
                end
                r_frame_xor <= 8'h00;
                r_state     <= S_DATA;
            end
        end
    end
`else
    assign w_data_beat = w_accept;
    assign check_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_run       <= 1'b0;
            r_prev      <= SEED;
            r_count     <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_last  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (sync_clear) begin
                r_prev      <= SEED;
                r_count     <= 8'h00;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
                // A new beat overrides the drain above, giving full throughput
                if (w_data_beat) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_decoded;
                    r_out_last  <= w_is_last;
                    if (w_is_last) begin
                        r_prev  <= SEED;
                        r_count <= 8'h00;
                    end else begin
                        r_prev  <= w_decoded;
                        r_count <= r_count + 8'd1;
                    end
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign byte_count = r_count;

endmodule

// File: tb/tb_xor_chain_decoder.sv
// Directed bench for xor_chain_decoder with FRAME_LEN=4; check-byte cases run when XOR_CHAIN_DEC_CHECK_EN is defined.
module tb_xor_chain_decoder;

    localparam int FL = 4;
`ifdef XOR_CHAIN_DEC_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       sync_clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic [7:0] byte_count;
    logic       check_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    xor_chain_decoder #(.OFFSET(8'h22), .SEED(8'h03), .FRAME_LEN(FL)) dut (
        .clk(clk), .clear_n(clear_n), .sync_clear(sync_clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .byte_count(byte_count), .check_err(check_err)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one encoded byte and hold it until the edge that accepts it
    task automatic push(input logic [7:0] y);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = y;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("push_ready", {15'd0, in_ready}, 16'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("push y=%h -> out_valid=%0d out_data=%h last=%0d count=%0d err=%0d",
                 y, out_valid, out_data, out_last, byte_count, check_err);
    endtask

    // Push a data byte and check the resulting beat
    task automatic push_data(input string tag, input logic [7:0] y, input logic [7:0] x,
                             input logic last, input logic [7:0] cnt);
        push(y);
        check_eq({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
        check_eq({tag, "_data"},  {8'd0, out_data}, {8'd0, x});
        check_eq({tag, "_last"},  {15'd0, out_last}, {15'd0, last});
        check_eq({tag, "_count"}, {8'd0, byte_count}, {8'd0, cnt});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check_eq("rst_in_ready",  {15'd0, in_ready}, 16'd0);
        check_eq("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check_eq("rst_out_data",  {8'd0, out_data}, 16'h0000);
        check_eq("rst_out_last",  {15'd0, out_last}, 16'd0);
        check_eq("rst_count",     {8'd0, byte_count}, 16'd0);
        check_eq("rst_check_err", {15'd0, check_err}, 16'd0);
        out_ready = 1'b1;
        @(negedge clk);
        clear_n = 1'b1;
        #1;
        check_eq("release_in_ready_low", {15'd0, in_ready}, 16'd0);
        @(posedge clk);
        #1;
        check_eq("release_in_ready_high", {15'd0, in_ready}, 16'd1);

        // Basic decode: 03+22=25, 35^25=10; 10+22=32, CD^32=FF
        push_data("basic0", 8'h35, 8'h10, 1'b0, 8'd1);
        push_data("basic1", 8'hCD, 8'hFF, 1'b0, 8'd2);

        // Backpressure: FF pending, D1 waiting (FF+22=21, D1^21=F0)
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hD1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_in_ready", {15'd0, in_ready}, 16'd0);
            check_eq("bp_out_data", {8'd0, out_data}, 16'h00FF);
            check_eq("bp_out_valid", {15'd0, out_valid}, 16'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", {15'd0, in_ready}, 16'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("push y=d1 -> out_valid=%0d out_data=%h last=%0d count=%0d err=%0d",
                 out_valid, out_data, out_last, byte_count, check_err);
        check_eq("bp_resume_data",  {8'd0, out_data}, 16'h00F0);
        check_eq("bp_resume_valid", {15'd0, out_valid}, 16'd1);
        check_eq("bp_resume_count", {8'd0, byte_count}, 16'd3);

        // Wrap and frame end: (F0+22) mod 256 = 12, 12^12=00
        push_data("wrap_last", 8'h12, 8'h00, 1'b1, 8'd0);

`ifdef XOR_CHAIN_DEC_CHECK_EN
        // Frame XOR 10^FF^F0^00 = 1F
        push(8'h1F);
        check_eq("chk_ok_no_beat", {15'd0, out_valid}, 16'd0);
        check_eq("chk_ok_count",   {8'd0, byte_count}, 16'd0);
        check_eq("chk_ok_err",     {15'd0, check_err}, 16'd0);
`endif

        // Second frame against SEED: 25^25=00, 32^22=10, CD^32=FF, 2E^21=0F
        push_data("f2_b0", 8'h25, 8'h00, 1'b0, 8'd1);
        push_data("f2_b1", 8'h32, 8'h10, 1'b0, 8'd2);
        push_data("f2_b2", 8'hCD, 8'hFF, 1'b0, 8'd3);
        push_data("f2_b3", 8'h2E, 8'h0F, 1'b1, 8'd0);

`ifdef XOR_CHAIN_DEC_CHECK_EN
        // Frame XOR 00^10^FF^0F = E0; send E1
        push(8'hE1);
        check_eq("chk_bad_no_beat", {15'd0, out_valid}, 16'd0);
        check_eq("chk_bad_err",     {15'd0, check_err}, 16'd1);
`endif

        push_data("f3_b0", 8'h25, 8'h00, 1'b0, 8'd1);
        push_data("f3_b1", 8'h32, 8'h10, 1'b0, 8'd2);
        check_eq("err_sticky", {15'd0, check_err}, {15'd0, CHK});

        // Mid-frame resync with a pending beat and a byte on the input
        @(negedge clk);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h77;
        sync_clear = 1'b1;
        #1;
        check_eq("sc_in_ready", {15'd0, in_ready}, 16'd0);
        @(posedge clk);
        #1;
        check_eq("sc_out_valid", {15'd0, out_valid}, 16'd0);
        check_eq("sc_out_last",  {15'd0, out_last}, 16'd0);
        check_eq("sc_count",     {8'd0, byte_count}, 16'd0);
        check_eq("sc_check_err", {15'd0, check_err}, 16'd0);
        @(negedge clk);
        sync_clear = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        push_data("post_sc", 8'h25, 8'h00, 1'b0, 8'd1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
